// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a ready/valid handshake, a one-entry skid buffer,
// a flush that turns held instructions into bubbles, and a saturating stall counter.
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_count
);

    // Occupancy is encoded directly by {main_valid, skid_valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic              r_main_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic              r_skid_valid;
    logic [CNT_W-1:0]  r_stall_count;

    state_t            w_state;
    logic              w_accept;
    logic              w_emit;
    logic              w_stall;
    logic              w_cnt_max;

    // Upstream input is ignored while flushing, so a flush cycle never accepts.
    assign w_state   = state_t'({r_main_valid, r_skid_valid});
    assign w_accept  = in_valid && !r_skid_valid && !flush;
    assign w_emit    = r_main_valid && out_ready;
    assign w_stall   = r_main_valid && !out_ready;
    assign w_cnt_max = (r_stall_count == {CNT_W{1'b1}});

    assign in_ready    = !r_skid_valid;
    assign out_valid   = r_main_valid;
    assign out_data    = r_main_data;
    assign out_ctrl    = r_main_ctrl;
    assign stall_count = r_stall_count;

    // Main/skid storage: handshake transitions, flush-to-bubble, reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_main_data  <= '0;
            r_main_ctrl  <= '0;
            r_main_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_ctrl  <= '0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            // Payload is kept; only the control and valid bits are squashed.
            r_main_ctrl  <= '0;
            r_main_valid <= 1'b0;
            r_skid_ctrl  <= '0;
            r_skid_valid <= 1'b0;
        end else begin
            case (w_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_main_data  <= in_data;
                        r_main_ctrl  <= in_ctrl;
                        r_main_valid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_emit) begin
                        r_main_data <= in_data;
                        r_main_ctrl <= in_ctrl;
                    end else if (w_accept) begin
                        r_skid_data  <= in_data;
                        r_skid_ctrl  <= in_ctrl;
                        r_skid_valid <= 1'b1;
                    end else if (w_emit) begin
                        r_main_ctrl  <= '0;
                        r_main_valid <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (w_emit) begin
                        r_main_data  <= r_skid_data;
                        r_main_ctrl  <= r_skid_ctrl;
                        r_skid_ctrl  <= '0;
                        r_skid_valid <= 1'b0;
                    end
                end
                default: begin
                    // Recover from the unreachable encoding by dropping to EMPTY.
                    r_main_ctrl  <= '0;
                    r_main_valid <= 1'b0;
                    r_skid_ctrl  <= '0;
                    r_skid_valid <= 1'b0;
                end
            endcase
        end
    end

    // Back-pressure counter: counts presented-but-refused cycles, saturating; flush-immune.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (w_stall && !w_cnt_max) begin
            r_stall_count <= r_stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios plus a randomized
// run against a queue-based occupancy model.
module tb_pipe_stage_skid;

    localparam int MAXC = 65535;

    logic        clk = 1'b0;
    logic        reset, in_valid, out_ready, flush;
    logic [31:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [7:0]  out_ctrl;
    logic [15:0] stall_count;

    logic        s_reset, s_in_valid, s_out_ready, s_flush;
    logic [31:0] s_in_data;
    logic [7:0]  s_in_ctrl;
    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_data;
    logic [7:0]  s_out_ctrl;
    logic [3:0]  s_stall;

    int          total = 0;
    int          bad   = 0;
    logic [39:0] mq[$];
    int          m_stall = 0;

    always #5 clk = ~clk;

    pipe_stage_skid dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .flush(flush), .stall_count(stall_count)
    );

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .CNT_W(4)) dut4 (
        .clk(clk), .reset(s_reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .in_ctrl(s_in_ctrl), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
        .flush(s_flush), .stall_count(s_stall)
    );

    // Advance one clock; the model sees the same inputs the DUT samples at the edge.
    task automatic step();
        int sz;
        sz = mq.size();
        if (reset) begin
            mq.delete();
            m_stall = 0;
        end else begin
            if (sz > 0 && !out_ready && m_stall < MAXC) m_stall++;
            if (sz > 0 && out_ready) void'(mq.pop_front());
            if (flush) mq.delete();
            else if (in_valid && sz < 2) mq.push_back({in_ctrl, in_data});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < n; i++) step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2);
        in_valid = 1'b1; in_data = 32'hDEADBEEF; in_ctrl = 8'h5A; out_ready = 1'b1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b want=0", out_valid); end
        total++; if (out_ctrl !== 8'h00) begin bad++; $display("FAIL rst_out_ctrl got=%h want=00", out_ctrl); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rst_out_data got=%h want=0", out_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b want=1", in_ready); end
        total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL rst_stall got=%0d want=0", stall_count); end
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_ctrl !== 8'h5A) begin
            bad++; $display("FAIL latency got=%0b/%h/%h want=1/deadbeef/5a", out_valid, out_data, out_ctrl);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset(1);
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h11;
        in_data = 32'h1; step();
        in_data = 32'h2; step();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_full got=%0b want=0", in_ready); end
        reset = 1'b1; flush = 1'b1; out_ready = 1'b1; in_data = 32'h3;
        step();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ctrl !== 8'h00 || stall_count !== 16'd0) begin
            bad++; $display("FAIL mid_reset got=v%0b r%0b c%h s%0d want=v0 r1 c00 s0", out_valid, in_ready, out_ctrl, stall_count);
        end
    endtask

    task automatic test_stream();
        do_reset(1);
        out_ready = 1'b1; in_ctrl = 8'h01;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = 32'(i);
            step();
            total++; if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
                bad++; $display("FAIL stream_data got=%0b/%0d want=1/%0d", out_valid, out_data, i);
            end
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready i=%0d got=%0b want=1", i, in_ready); end
        end
        in_valid = 1'b0; step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%0b want=0", out_valid); end
        total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL stream_stall got=%0d want=0", stall_count); end
    endtask

    task automatic test_skid();
        do_reset(1);
        out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 8'h22;
        in_data = 32'd1; step();
        in_data = 32'd2; out_ready = 1'b0; step();
        in_data = 32'd3;
        for (int k = 0; k < 2; k++) step();
        total++; if (out_data !== 32'd1 || out_valid !== 1'b1) begin bad++; $display("FAIL skid_hold got=%0d want=1", out_data); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL skid_ready got=%0b want=0", in_ready); end
        out_ready = 1'b1; step();
        total++; if (out_data !== 32'd2 || in_ready !== 1'b1) begin
            bad++; $display("FAIL skid_second got=%0d/r%0b want=2/r1", out_data, in_ready);
        end
        step();
        in_valid = 1'b0;
        total++; if (out_data !== 32'd3 || out_valid !== 1'b1) begin bad++; $display("FAIL skid_third got=%0d want=3", out_data); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL skid_nodup got=%0b want=0", out_valid); end
        total++; if (stall_count !== 16'd3) begin bad++; $display("FAIL skid_stall got=%0d want=3", stall_count); end
    endtask

    task automatic test_flush();
        do_reset(1);
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'hFF;
        in_data = 32'hA1; step();
        in_data = 32'hA2; step();
        flush = 1'b1; in_data = 32'hA3; step();
        flush = 1'b0;
        total++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || in_ready !== 1'b1) begin
            bad++; $display("FAIL flush_state got=v%0b c%h r%0b want=v0 c00 r1", out_valid, out_ctrl, in_ready);
        end
        in_data = 32'hB4; in_ctrl = 8'h33; out_ready = 1'b1; step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 32'hB4 || out_ctrl !== 8'h33) begin
            bad++; $display("FAIL flush_next got=%0b/%h/%h want=1/b4/33", out_valid, out_data, out_ctrl);
        end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_a3_gone got=%0b want=0", out_valid); end
    endtask

    task automatic test_saturation();
        s_reset = 1'b1; s_in_valid = 1'b0; s_out_ready = 1'b0; s_flush = 1'b0;
        s_in_data = 32'h77; s_in_ctrl = 8'h44;
        step();
        s_reset = 1'b0; s_in_valid = 1'b1; step();
        s_in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 10) begin
                total++; if (s_stall !== 4'd10) begin bad++; $display("FAIL sat_mid got=%0d want=10", s_stall); end
            end
        end
        total++; if (s_stall !== 4'd15) begin bad++; $display("FAIL sat_max got=%0d want=15", s_stall); end
        s_flush = 1'b1; step(); s_flush = 1'b0;
        total++; if (s_stall !== 4'd15 || s_out_valid !== 1'b0) begin
            bad++; $display("FAIL sat_flush got=%0d/v%0b want=15/v0", s_stall, s_out_valid);
        end
        s_reset = 1'b1; step(); s_reset = 1'b0;
        total++; if (s_stall !== 4'd0) begin bad++; $display("FAIL sat_reset got=%0d want=0", s_stall); end
    endtask

    task automatic test_random();
        do_reset(1);
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            in_data   = $urandom;
            in_ctrl   = 8'($urandom);
            step();
            total++; if (out_valid !== (mq.size() > 0)) begin
                bad++; $display("FAIL rnd_valid c=%0d got=%0b want=%0b", c, out_valid, mq.size() > 0);
            end
            total++; if (in_ready !== (mq.size() < 2)) begin
                bad++; $display("FAIL rnd_ready c=%0d got=%0b want=%0b", c, in_ready, mq.size() < 2);
            end
            total++; if (!in_ready && !out_valid) begin
                bad++; $display("FAIL rnd_illegal c=%0d got=skid_only want=legal", c);
            end
            total++; if (stall_count !== 16'(m_stall)) begin
                bad++; $display("FAIL rnd_stall c=%0d got=%0d want=%0d", c, stall_count, m_stall);
            end
            if (mq.size() > 0) begin
                total++; if ({out_ctrl, out_data} !== mq[0]) begin
                    bad++; $display("FAIL rnd_data c=%0d got=%h want=%h", c, {out_ctrl, out_data}, mq[0]);
                end
            end else begin
                total++; if (out_ctrl !== 8'h00) begin
                    bad++; $display("FAIL rnd_bubble_ctrl c=%0d got=%h want=00", c, out_ctrl);
                end
            end
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        in_data = 32'h0; in_ctrl = 8'h00;
        s_reset = 1'b1; s_in_valid = 1'b0; s_out_ready = 1'b0; s_flush = 1'b0;
        s_in_data = 32'h0; s_in_ctrl = 8'h00;
        @(negedge clk);
        test_reset();
        test_reset_midflight();
        test_stream();
        test_skid();
        test_flush();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register, the successor to our fixed-field stage registers such as the execute/memory register. It carries a DATA_W-bit payload and a CTRL_W-bit control field between two pipeline stages. It adds a ready/valid handshake with a one-entry skid buffer, so full throughput is kept under back-pressure. It also provides a flush that squashes in-flight instructions into bubbles, and a saturating back-pressure counter for performance analysis.

## Interface
Parameters:
- DATA_W, 32, width of payload (ALU result, store data, addresses; never cleared by flush)
- CTRL_W, 8, width of control field (write enables, select bits; forced to 0 for bubbles)
- CNT_W, 16, width of stall counter

Ports:
- clk  input  1  single clock, all state updates on posedge
- reset  input  1  synchronous, active-high
- in_valid  input  1  upstream holds a valid instruction
- in_ready  output  1  stage can accept this cycle
- in_data  input  DATA_W  upstream payload
- in_ctrl  input  CTRL_W  upstream control field
- out_valid  output  1  stage presents a valid instruction
- out_ready  input  1  downstream accepts this cycle
- out_data  output  DATA_W  payload to downstream
- out_ctrl  output  CTRL_W  control field to downstream; 0 whenever out_valid=0
- flush  input  1  squash all held instructions
- stall_count  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Storage: main register (drives out_*) and skid register. Each register holds a data field, a ctrl field and a valid bit.
- in_ready = !skid_valid. It is a function of registered state only, with no combinational path from out_ready.
- Accept = in_valid && in_ready. Emit = out_valid && out_ready.
- State is encoded by the valid bits: EMPTY (main=0, skid=0), ONE (main=1, skid=0), FULL (main=1, skid=1). The combination main=0, skid=1 is illegal.
- EMPTY:
  - Accept → main ← in, go to ONE.
  - Otherwise stay.
- ONE:
  - Accept && Emit → main ← in, stay in ONE.
  - Accept && !Emit → skid ← in, go to FULL.
  - !Accept && Emit → go to EMPTY; main ctrl cleared to 0.
  - Otherwise hold.
- FULL (in_ready=0):
  - Emit → main ← skid, skid cleared (ctrl=0), go to ONE.
  - Otherwise hold.
- Flush takes priority over all transitions except reset:
  - Both valid bits and both ctrl fields are cleared.
  - Data fields are retained.
  - The state becomes EMPTY.
  - in_valid is ignored in the flush cycle.
  - An Emit occurring in the flush cycle completes normally from downstream's view.
- Invariant: out_ctrl == 0 whenever out_valid == 0, including after reset, after a drain and after a flush.
- Ordering: instructions leave in acceptance order; no loss and no duplication.
- stall_count:
  - +1 on every cycle with out_valid && !out_ready.
  - Saturates at 2^CNT_W−1.
  - Cleared only by reset; unaffected by flush.

## Timing
- Reset (sampled high at a posedge): next cycle out_valid=0, out_data=0, out_ctrl=0, in_ready=1, stall_count=0, skid cleared.
- Reset asserted mid-transfer discards both entries regardless of in_valid, out_ready or flush.
- Latency: accept at edge N → out_valid=1 with that data from N+1 (one cycle).
- Throughput: one instruction per cycle while out_ready stays 1; in_ready remains 1.
- in_ready drops the cycle after the first Accept made while out_ready=0 (transition to FULL). It returns the cycle after the Emit that drains the skid register.
- No instruction is lost when out_ready is deasserted on the same cycle upstream presents data; that instruction goes to the skid register.
- Flush at edge N: from N+1, out_valid=0, out_ctrl=0 and in_ready=1. An Accept is possible at N+1.
- stall_count updates one cycle after the stalled cycle it counts.

## Test plan
- Reset/latency: assert reset 2 cycles, then in_valid=1, data=0xDEADBEEF, ctrl=0x5A, out_ready=1. Required response:
  - First cycle after reset: out_valid=0, out_ctrl=0, in_ready=1.
  - One cycle after accept: out_data=0xDEADBEEF, out_ctrl=0x5A.
- Streaming: 16 back-to-back inputs 0..15 with out_ready=1 → outputs 0..15 on consecutive cycles, in_ready constantly 1, stall_count=0.
- Skid: stream 1,2,3 and drop out_ready on the cycle 2 is accepted, holding it low 3 cycles. Required response:
  - out_data stays 1.
  - in_ready=0 for the stall duration.
  - 3 is not accepted until space frees.
  - Outputs are then 1,2,3 in order, no duplicates.
  - stall_count=3.
- Flush in FULL: fill both entries (ctrl=0xFF), then pulse flush with in_valid=1 → next cycle out_valid=0, out_ctrl=0, in_ready=1. The flush-cycle input is never emitted; a new input is accepted next cycle and emitted normally.
- Saturation: CNT_W=4, hold out_valid=1 with out_ready=0 for 20 cycles → stall_count reaches 15 and holds. A subsequent flush leaves it at 15; reset clears it to 0.
- Random: random in_valid, out_ready and sparse flush over 10k cycles against a scoreboard model. Required response:
  - Order and data integrity are preserved.
  - out_ctrl=0 whenever out_valid=0.
  - The illegal state never occurs.
